// File: rtl/actuator_phase_sequencer.sv
// Actuator phase sequencer.
// A pad trigger starts a timed run through SETUP, DRIVE, HOLD and RELEASE.
// The phase boundaries come from four compare values that are captured when
// the run starts. Set coils are driven during DRIVE and release coils during
// RELEASE. Every output is registered from the next-state values, so each
// output changes on the same clock edge as the state it reflects.
module actuator_phase_sequencer #(
  parameter int N_ACT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable_n,
  input  logic             trigger_in_n,
  input  logic [31:0]      ccr0,
  input  logic [31:0]      ccr1,
  input  logic [31:0]      ccr2,
  input  logic [31:0]      ccr3,
  input  logic [N_ACT-1:0] pattern,
  input  logic             clr_status,
  output logic [N_ACT-1:0] act_set,
  output logic [N_ACT-1:0] act_clr,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, SETUP, DRIVE, HOLD, RELEASE} state_t;

  state_t             state_q, state_next;
  logic [31:0]        cnt_q, cnt_next;
  logic [32:0]        cnt_inc;
  logic [31:0]        ccr0_q, ccr1_q, ccr2_q, ccr3_q;
  logic [31:0]        ccr0_next, ccr1_next, ccr2_next, ccr3_next;
  logic [N_ACT-1:0]   pattern_q, pattern_next;
  logic [N_ACT-1:0]   act_set_next, act_clr_next;
  logic               busy_next, done_next, cfg_err_next, overrun_next;
  logic               trig_sync1, trig_sync2, trig_prev;
  logic               start_strobe;

  // Maps a cycle count to its phase. The count is assumed to be below ccr3.
  // A phase whose two boundaries are equal never matches, so it is skipped.
  function automatic state_t phase_of(input logic [31:0] c,
                                      input logic [31:0] b0,
                                      input logic [31:0] b1,
                                      input logic [31:0] b2);
    if (c < b0)      return SETUP;
    else if (c < b1) return DRIVE;
    else if (c < b2) return HOLD;
    else             return RELEASE;
  endfunction

  // Synchronizes the asynchronous pad trigger and keeps the previous sample.
  // The previous sample is used to find the falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync1 <= 1'b1;
      trig_sync2 <= 1'b1;
      trig_prev  <= 1'b1;
    end else begin
      trig_sync1 <= trigger_in_n;
      trig_sync2 <= trig_sync1;
      trig_prev  <= trig_sync2;
    end
  end

  assign start_strobe = trig_prev & ~trig_sync2;
  assign cnt_inc      = {1'b0, cnt_q} + 33'd1;

  // Next-state logic: decides whether a start is accepted, advances the run,
  // handles aborts, and updates the sticky flags. When a flag is cleared and
  // set in the same cycle, the set is applied last so it takes effect.
  always_comb begin
    state_next   = state_q;
    cnt_next     = cnt_q;
    ccr0_next    = ccr0_q;
    ccr1_next    = ccr1_q;
    ccr2_next    = ccr2_q;
    ccr3_next    = ccr3_q;
    pattern_next = pattern_q;
    done_next    = 1'b0;
    cfg_err_next = cfg_err;
    overrun_next = overrun;

    if (clr_status) begin
      cfg_err_next = 1'b0;
      overrun_next = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_strobe && !enable_n) begin
          ccr0_next    = ccr0;
          ccr1_next    = ccr1;
          ccr2_next    = ccr2;
          ccr3_next    = ccr3;
          pattern_next = pattern;
          cnt_next     = '0;
          if (!((ccr0 <= ccr1) && (ccr1 <= ccr2) && (ccr2 <= ccr3))) begin
            cfg_err_next = 1'b1;
            done_next    = 1'b1;
          end else begin
            cfg_err_next = 1'b0;
            if (ccr3 == 32'd0) done_next  = 1'b1;
            else               state_next = phase_of(32'd0, ccr0, ccr1, ccr2);
          end
        end
      end
      default: begin
        if (start_strobe) overrun_next = 1'b1;
        if (enable_n) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc >= {1'b0, ccr3_q}) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next   = cnt_inc[31:0];
          state_next = phase_of(cnt_inc[31:0], ccr0_q, ccr1_q, ccr2_q);
        end
      end
    endcase

    busy_next    = (state_next != IDLE);
    act_set_next = (state_next == DRIVE)   ? pattern_next : '0;
    act_clr_next = (state_next == RELEASE) ? pattern_next : '0;
  end

  // Registers the state, the counter, the shadow copies and every output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ccr0_q    <= '0;
      ccr1_q    <= '0;
      ccr2_q    <= '0;
      ccr3_q    <= '0;
      pattern_q <= '0;
      act_set   <= '0;
      act_clr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_next;
      cnt_q     <= cnt_next;
      ccr0_q    <= ccr0_next;
      ccr1_q    <= ccr1_next;
      ccr2_q    <= ccr2_next;
      ccr3_q    <= ccr3_next;
      pattern_q <= pattern_next;
      act_set   <= act_set_next;
      act_clr   <= act_clr_next;
      busy      <= busy_next;
      done      <= done_next;
      cfg_err   <= cfg_err_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_actuator_phase_sequencer.sv
// Testbench for actuator_phase_sequencer.
// For each busy cycle k, the expected phase outputs are computed from the
// boundary rules: drive while ccr0<=k<ccr1, release while ccr2<=k<ccr3.
module tb_actuator_phase_sequencer;

  localparam int N = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable_n;
  logic          trigger_in_n;
  logic [31:0]   ccr0, ccr1, ccr2, ccr3;
  logic [N-1:0]  pattern;
  logic          clr_status;
  logic [N-1:0]  act_set, act_clr;
  logic          busy, done, cfg_err, overrun;

  int n_checks = 0;
  int n_fails  = 0;
  bit exp_ovr  = 1'b0;

  actuator_phase_sequencer #(.N_ACT(N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable_n     (enable_n),
    .trigger_in_n (trigger_in_n),
    .ccr0         (ccr0),
    .ccr1         (ccr1),
    .ccr2         (ccr2),
    .ccr3         (ccr3),
    .pattern      (pattern),
    .clr_status   (clr_status),
    .act_set      (act_set),
    .act_clr      (act_clr),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .overrun      (overrun)
  );

  // Free-running clock with a 10-unit period.
  always #5 clock = ~clock;

  // Compares one observed value against its expected value.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks that the block is idle with both coil outputs off.
  task automatic check_quiet(input string tag, input logic exp_done);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'(exp_done));
    check_output({tag, "_set"}, 32'(act_set), 32'd0);
    check_output({tag, "_clr"}, 32'(act_clr), 32'd0);
  endtask

  // Runs one triggered sequence and checks every cycle against the boundary
  // rules. Optional events: a second trigger at busy cycle ovr_at, an abort
  // at busy cycle abort_at, and a reset pulse at busy cycle reset_at.
  // Passing -1 disables an event.
  task automatic apply_stimulus(input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [31:0] c3,
                                input logic [N-1:0] pat, input int ovr_at,
                                input int abort_at, input int reset_at);
    bit     valid;
    longint n_busy;
    bit     eo;
    valid  = (c0 <= c1) && (c1 <= c2) && (c2 <= c3);
    n_busy = valid ? longint'(c3) : 0;
    ccr0 = c0; ccr1 = c1; ccr2 = c2; ccr3 = c3; pattern = pat;
    enable_n = 1'b0;
    trigger_in_n = 1'b0;
    tick();
    tick();
    check_output("pre_start_busy", 32'(busy), 32'd0);
    trigger_in_n = 1'b1;
    for (longint k = 0; k < n_busy; k++) begin
      tick();
      eo = exp_ovr || (ovr_at >= 0 && k >= longint'(ovr_at) + 3);
      check_output("run_busy", 32'(busy), 32'd1);
      check_output("run_done", 32'(done), 32'd0);
      check_output("run_set", 32'(act_set), (k >= c0 && k < c1) ? 32'(pat) : 32'd0);
      check_output("run_clr", 32'(act_clr), (k >= c2 && k < c3) ? 32'(pat) : 32'd0);
      check_output("run_cfg_err", 32'(cfg_err), 32'd0);
      check_output("run_overrun", 32'(overrun), 32'(eo));
      if (k == 0) begin
        ccr0 = $urandom; ccr1 = $urandom; ccr2 = $urandom; ccr3 = $urandom;
        pattern = N'($urandom);
      end
      if (k == longint'(ovr_at)) trigger_in_n = 1'b0;
      if (k == longint'(ovr_at) + 2) trigger_in_n = 1'b1;
      if (k == longint'(abort_at)) begin
        enable_n = 1'b1;
        tick();
        check_quiet("abort", 1'b0);
        tick();
        check_quiet("abort_after", 1'b0);
        enable_n = 1'b0;
        exp_ovr = eo;
        return;
      end
      if (k == longint'(reset_at)) begin
        #2 reset_n = 1'b0;
        #1;
        check_quiet("async_reset", 1'b0);
        check_output("async_reset_cfg", 32'(cfg_err), 32'd0);
        check_output("async_reset_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        exp_ovr = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          check_quiet("post_reset", 1'b0);
        end
        return;
      end
    end
    tick();
    check_quiet("end", 1'b1);
    check_output("end_cfg_err", 32'(cfg_err), valid ? 32'd0 : 32'd1);
    if (ovr_at >= 0) exp_ovr = 1'b1;
    check_output("end_overrun", 32'(overrun), 32'(exp_ovr));
    tick();
    check_output("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Directed scenarios first, then randomized sequences.
  initial begin
    logic [31:0] r0, r1, r2, r3;
    reset_n = 1'b0; enable_n = 1'b0; trigger_in_n = 1'b1; clr_status = 1'b0;
    ccr0 = '0; ccr1 = '0; ccr2 = '0; ccr3 = '0; pattern = '0;
    #12;
    check_quiet("reset", 1'b0);
    check_output("reset_cfg_err", 32'(cfg_err), 32'd0);
    check_output("reset_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();
    check_quiet("idle", 1'b0);

    $display("[TB] nominal run");
    apply_stimulus(32'h8, 32'h0F, 32'h80, 32'hF0, 16'hA5A5, -1, -1, -1);
    $display("[TB] zero-length phases");
    apply_stimulus(32'd0, 32'd4, 32'd4, 32'd6, 16'h3C0F, -1, -1, -1);
    $display("[TB] non-monotonic compare values");
    apply_stimulus(32'h20, 32'h10, 32'h30, 32'h40, 16'hFFFF, -1, -1, -1);
    apply_stimulus(32'd1, 32'd2, 32'd3, 32'd5, 16'h1234, -1, -1, -1);
    $display("[TB] overrun");
    apply_stimulus(32'd2, 32'd10, 32'd60, 32'd70, 16'h0F0F, 50, -1, -1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    exp_ovr = 1'b0;
    check_output("clr_overrun", 32'(overrun), 32'd0);
    $display("[TB] abort with maximum ccr3");
    apply_stimulus(32'd2, 32'd20, 32'd30, 32'hFFFF_FFFF, 16'h8001, -1, 5, -1);
    enable_n = 1'b1;
    trigger_in_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) trigger_in_n = 1'b1;
      check_quiet("disabled_trigger", 1'b0);
      check_output("disabled_overrun", 32'(overrun), 32'd0);
    end
    enable_n = 1'b0;
    $display("[TB] ccr3 zero");
    apply_stimulus(32'd0, 32'd0, 32'd0, 32'd0, 16'h5555, -1, -1, -1);
    $display("[TB] reset during release");
    apply_stimulus(32'd3, 32'd5, 32'd7, 32'd20, 16'hC3C3, -1, -1, 10);
    apply_stimulus(32'd1, 32'd3, 32'd4, 32'd6, 16'h0FF0, -1, -1, -1);

    $display("[TB] randomized runs");
    for (int it = 0; it < 8; it++) begin
      r0 = $urandom_range(0, 6);
      r1 = r0 + $urandom_range(0, 8);
      r2 = r1 + $urandom_range(0, 8);
      r3 = r2 + $urandom_range(0, 8);
      if (it % 4 == 3) begin
        r0 = r1 + 32'd1;
      end
      apply_stimulus(r0, r1, r2, r3, N'($urandom), -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/actuator_phase_sequencer.md
ACTUATOR_PHASE_SEQUENCER -- requirements
Module: actuator_phase_sequencer

Interface
REQ-001 SHALL have parameter N_ACT, default 16: number of actuator channels.
REQ-002 SHALL have port clock, input, 1: single block clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port enable_n, input, 1: active-low run enable, synchronous to clock.
REQ-005 SHALL have port trigger_in_n, input, 1: active-low pad trigger, asynchronous to clock.
REQ-006 SHALL have ports ccr0, ccr1, ccr2, ccr3, input, 32 each: phase boundary compare values from the register bank.
REQ-007 SHALL have port pattern, input, N_ACT: dot pattern to actuate.
REQ-008 SHALL have port clr_status, input, 1: single-cycle pulse that clears the sticky flags.
REQ-009 SHALL have ports act_set and act_clr, output, N_ACT each: registered drive outputs for the set and release coils.
REQ-010 SHALL have port busy, output, 1: sequence in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-012 SHALL have port cfg_err, output, 1: sticky flag, non-monotonic CCR values.
REQ-013 SHALL have port overrun, output, 1: sticky flag, trigger arrived while busy.

Function
REQ-014 SHALL pass trigger_in_n through a 2-flop synchronizer, then a registered falling-edge detector, giving a start strobe 3 clocks after the pad falls.
REQ-015 SHALL use the states IDLE, SETUP, DRIVE, HOLD, RELEASE.
REQ-016 SHALL accept a start strobe in IDLE only when enable_n=0; a strobe seen with enable_n=1 is discarded and sets no flag.
REQ-017 SHALL, on an accepted start, latch ccr0..ccr3 and pattern into shadow registers; register-bank writes made during a run have no effect until the next start.
REQ-018 SHALL, on an accepted start, set cfg_err, pulse done, keep busy=0 and stay in IDLE when the latched values break ccr0<=ccr1<=ccr2<=ccr3.
REQ-019 SHALL, on an accepted start with valid values, clear cfg_err, zero a 32-bit cycle counter cnt and set busy=1 from the next clock.
REQ-020 SHALL advance cnt by 1 per clock while busy; cnt is 0 in the first busy cycle.
REQ-021 SHALL hold the run in SETUP while cnt<ccr0, DRIVE while ccr0<=cnt<ccr1, HOLD while ccr1<=cnt<ccr2 and RELEASE while ccr2<=cnt<ccr3.
REQ-022 SHALL skip any zero-length phase in the same cycle.
REQ-023 SHALL end the run when cnt reaches ccr3: return to IDLE, busy=0, one-cycle done pulse.
REQ-024 SHALL run no busy cycles when ccr3=0, giving a done pulse only.
REQ-025 SHALL drive act_set=latched pattern only in DRIVE cycles and act_clr=latched pattern only in RELEASE cycles, otherwise all zero.
REQ-026 SHALL never assert act_set and act_clr for the same channel in the same cycle.
REQ-027 SHALL make all outputs registered, with phase-aligned output timing, i.e. no extra lag versus the state.
REQ-028 SHALL, on a start strobe while busy, ignore it (the run continues unchanged) and set overrun.
REQ-029 SHALL, when enable_n=1 while busy, abort: next cycle state=IDLE, act_set=act_clr=0, busy=0, no done pulse.
REQ-030 SHALL let clr_status clear overrun and cfg_err; when it coincides with a setting event in the same cycle, the set wins.
REQ-031 SHALL never wrap cnt; ccr3=32'hFFFFFFFF is a legal maximum.

Reset
REQ-032 SHALL, on reset_n=0, immediately and asynchronously set state=IDLE, cnt=0, act_set=0, act_clr=0, busy=0, done=0, cfg_err=0, overrun=0, synchronizer flops=1 and shadow registers=0.
REQ-033 SHALL, after reset_n is released mid-run, resume nothing; a new trigger is required.

Verification
REQ-034 SHALL pass this scenario: ccr=8/0x0F/0x80/0xF0, pattern=16'hA5A5, pad trigger -> busy rises 3 clocks after the pad fall; SETUP 8, DRIVE 7 (act_set=A5A5), HOLD 113, RELEASE 112 (act_clr=A5A5) cycles; done at busy-cycle 240.
REQ-035 SHALL pass this scenario: ccr=0/4/4/6 -> DRIVE at cnt 0..3, HOLD skipped, RELEASE at cnt 4..5, done after 6 busy cycles.
REQ-036 SHALL pass this scenario: ccr1=0x10 with ccr0=0x20, trigger -> cfg_err=1, done pulse, busy stays 0, outputs stay 0; next valid trigger clears cfg_err.
REQ-037 SHALL pass this scenario: second trigger at cnt=50 of a run -> run timing unchanged, overrun=1; clr_status -> overrun=0.
REQ-038 SHALL pass this scenario: enable_n=1 during DRIVE -> next cycle act_set=0, busy=0, no done; trigger with enable_n=1 -> no response.
REQ-039 SHALL pass this scenario: reset_n pulsed low during RELEASE -> all outputs 0 asynchronously, state IDLE; no activity until a new trigger.
